// File: rtl/rv_alu.sv
// Execute-stage ALU: combinational RV32I ops plus a multi-cycle M-extension unit
// (single-step multiply, 32-step restoring divide) that reports completion on cmpl.
module rv_alu (
  input  logic        clk,
  input  logic        xreset,
  input  logic        rdy,
  input  logic [4:0]  alu,
  input  logic [31:0] rrd1,
  input  logic [31:0] rrd2,
  input  logic [31:0] csr_rd,
  output logic [31:0] rwdat,
  output logic [31:0] rwdatx,
  output logic        cmpl,
  output logic        mulop
);

  typedef enum logic [4:0] {
    A_NA     = 5'd0,  A_ADD  = 5'd1,  A_SUB  = 5'd2,  A_SLL    = 5'd3,
    A_SLT    = 5'd4,  A_SLTU = 5'd5,  A_XOR  = 5'd6,  A_SRL    = 5'd7,
    A_SRA    = 5'd8,  A_OR   = 5'd9,  A_AND  = 5'd10, A_CSR    = 5'd11,
    A_MUL    = 5'd16, A_MULH = 5'd17, A_MULHSU = 5'd18, A_MULHU = 5'd19,
    A_DIV    = 5'd20, A_DIVU = 5'd21, A_REM  = 5'd22, A_REMU   = 5'd23
  } alu_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [4:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] rem_q, quo_q;

  logic        signed_div;
  logic [31:0] div_mag;
  logic [32:0] shifted;
  logic [31:0] step_diff;
  logic        step_ge;
  logic [31:0] step_rem, step_quo;
  logic        sa, sb;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] final_res;

  assign mulop = alu[4];

  always_comb begin
    rwdat = 32'd0;
    case (alu)
      A_ADD:  rwdat = rrd1 + rrd2;
      A_SUB:  rwdat = rrd1 - rrd2;
      A_SLL:  rwdat = rrd1 << rrd2[4:0];
      A_SLT:  rwdat = {31'd0, $signed(rrd1) < $signed(rrd2)};
      A_SLTU: rwdat = {31'd0, rrd1 < rrd2};
      A_XOR:  rwdat = rrd1 ^ rrd2;
      A_SRL:  rwdat = rrd1 >> rrd2[4:0];
      A_SRA:  rwdat = $signed(rrd1) >>> rrd2[4:0];
      A_OR:   rwdat = rrd1 | rrd2;
      A_AND:  rwdat = rrd1 & rrd2;
      A_CSR:  rwdat = csr_rd;
      default: rwdat = 32'd0;
    endcase
  end

  // DIV/REM (codes 20/22) are the signed divide ops; they run on magnitudes.
  assign signed_div = (op_q == A_DIV) || (op_q == A_REM);
  assign div_mag    = (signed_div && b_q[31]) ? -b_q : b_q;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign shifted   = {rem_q, quo_q[31]};
  assign step_ge   = shifted >= {1'b0, div_mag};
  assign step_diff = shifted[31:0] - div_mag;
  assign step_rem  = step_ge ? step_diff : shifted[31:0];
  assign step_quo  = {quo_q[30:0], step_ge};

  // Only the low 64 bits of the product matter, so 64-bit extended operands suffice.
  assign sa    = (op_q == A_MULH) || (op_q == A_MULHSU);
  assign sb    = (op_q == A_MULH);
  assign a_ext = {{32{sa & a_q[31]}}, a_q};
  assign b_ext = {{32{sb & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  always_comb begin
    final_res = 32'd0;
    case (op_q)
      A_MUL:                      final_res = prod[31:0];
      A_MULH, A_MULHSU, A_MULHU:  final_res = prod[63:32];
      A_DIV:  final_res = (b_q == 32'd0) ? 32'hFFFF_FFFF :
                          (a_q[31] ^ b_q[31]) ? -step_quo : step_quo;
      A_DIVU: final_res = (b_q == 32'd0) ? 32'hFFFF_FFFF : step_quo;
      A_REM:  final_res = (b_q == 32'd0) ? a_q : (a_q[31] ? -step_rem : step_rem);
      A_REMU: final_res = (b_q == 32'd0) ? a_q : step_rem;
      default: final_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mulop) state_d = BUSY;
      BUSY:    if (cnt_q == 6'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      rwdatx  <= 32'd0;
      cmpl    <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (mulop) begin
          op_q  <= alu;
          a_q   <= rrd1;
          b_q   <= rrd2;
          cnt_q <= alu[2] ? 6'd32 : 6'd1;
          rem_q <= 32'd0;
          quo_q <= ((alu == A_DIV || alu == A_REM) && rrd1[31]) ? -rrd1 : rrd1;
        end
        BUSY: begin
          cnt_q <= cnt_q - 6'd1;
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt_q == 6'd1) begin
            rwdatx <= final_res;
            cmpl   <= 1'b1;
          end
        end
        DONE: cmpl <= 1'b0;
        default: cmpl <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu: combinational ops, M-extension
// latency/results, divide corner cases, rdy stalls, reset abort and back-to-back ops.
module tb_rv_alu;

  logic        clk = 1'b0;
  logic        xreset;
  logic        rdy;
  logic [4:0]  alu;
  logic [31:0] rrd1, rrd2, csr_rd;
  logic [31:0] rwdat, rwdatx;
  logic        cmpl, mulop;

  int pass_cnt = 0;
  int check_cnt = 0;

  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;

  rv_alu dut (
    .clk    (clk),
    .xreset (xreset),
    .rdy    (rdy),
    .alu    (alu),
    .rrd1   (rrd1),
    .rrd2   (rrd2),
    .csr_rd (csr_rd),
    .rwdat  (rwdat),
    .rwdatx (rwdatx),
    .cmpl   (cmpl),
    .mulop  (mulop)
  );

  always #5 clk = ~clk;

  // Presents an M-op in cycle 0 and counts cycles until cmpl; caller must be just past a posedge.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input bit corrupt,
                        output int n, output logic [31:0] res, output logic pulse_after);
    bit done = 0;
    alu = op; rrd1 = a; rrd2 = b; rdy = 1'b1; n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1; n++;
      if (n == stall_at) rdy = 1'b0;
      if (n == stall_at + 3) rdy = 1'b1;
      if (corrupt && n == 3) rrd1 = 32'hDEAD_BEEF;
      if (cmpl) done = 1;
    end
    res = rwdatx;
    alu = 5'd0;
    @(posedge clk); #1;
    pulse_after = cmpl;
  endtask

  task automatic test_reset();
    xreset = 1'b0; rdy = 1'b1; alu = 5'd0; rrd1 = 32'd0; rrd2 = 32'd0; csr_rd = 32'd0;
    #2;
    check_cnt++;
    if (rwdatx !== 32'd0) $display("[TB] FAIL reset_rwdatx got %h want 0", rwdatx); else pass_cnt++;
    check_cnt++;
    if (cmpl !== 1'b0) $display("[TB] FAIL reset_cmpl got %b want 0", cmpl); else pass_cnt++;
    check_cnt++;
    if (mulop !== 1'b0) $display("[TB] FAIL reset_mulop got %b want 0", mulop); else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    xreset = 1'b1;
  endtask

  task automatic test_single_cycle();
    logic [4:0]  ops [14] = '{5'd1, 5'd2, 5'd8, 5'd4, 5'd5, 5'd11, 5'd3, 5'd7,
                              5'd6, 5'd9, 5'd10, 5'd0, 5'd12, 5'd16};
    logic [31:0] av  [14] = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h5, 32'h1, 32'h8000_0000, 32'hF0F0, 32'hF0F0, 32'hF0F0,
                              32'h5, 32'h5, 32'h5};
    logic [31:0] bv  [14] = '{32'h1, 32'h1, 32'h21, 32'h1, 32'h1, 32'h6, 32'h24, 32'h1F,
                              32'hFF00, 32'hFF00, 32'hFF00, 32'h6, 32'h6, 32'h6};
    logic [31:0] ev  [14] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hC000_0000, 32'h1, 32'h0,
                              32'h1234, 32'h10, 32'h1, 32'h0FF0, 32'hFFF0, 32'hF000,
                              32'h0, 32'h0, 32'h0};
    csr_rd = 32'h1234;
    for (int i = 0; i < 14; i++) begin
      alu = ops[i]; rrd1 = av[i]; rrd2 = bv[i];
      #1;
      check_cnt++;
      if (rwdat !== ev[i]) $display("[TB] FAIL rwdat_op%0d got %h want %h", ops[i], rwdat, ev[i]);
      else pass_cnt++;
    end
    alu = 5'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [4:0]  ops [4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] ev  [4] = '{32'h1, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int n; logic [31:0] res; logic pa;
    for (int i = 0; i < 4; i++) begin
      alu = ops[i]; rrd1 = 32'hFFFF_FFFF; rrd2 = 32'hFFFF_FFFF;
      #1;
      check_cnt++;
      if (mulop !== 1'b1 || rwdat !== 32'd0)
        $display("[TB] FAIL mul_comb_op%0d got mulop=%b rwdat=%h want 1/0", ops[i], mulop, rwdat);
      else pass_cnt++;
      run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, n, res, pa);
      check_cnt++;
      if (n !== 2) $display("[TB] FAIL mul_latency_op%0d got %0d want 2", ops[i], n); else pass_cnt++;
      check_cnt++;
      if (res !== ev[i]) $display("[TB] FAIL mul_result_op%0d got %h want %h", ops[i], res, ev[i]);
      else pass_cnt++;
      check_cnt++;
      if (pa !== 1'b0) $display("[TB] FAIL mul_pulse_op%0d got %b want 0", ops[i], pa); else pass_cnt++;
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [8] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] av  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h5, 32'h5,
                             32'h8000_0000, 32'h8000_0000, 32'h7, 32'h7};
    logic [31:0] bv  [8] = '{32'h2, 32'h2, 32'h0, 32'h0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] ev  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5,
                             32'h8000_0000, 32'h0, 32'hFFFF_FFFD, 32'h1};
    int n; logic [31:0] res; logic pa;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], av[i], bv[i], 0, 0, n, res, pa);
      check_cnt++;
      if (n !== 33) $display("[TB] FAIL div_latency_%0d got %0d want 33", i, n); else pass_cnt++;
      check_cnt++;
      if (res !== ev[i]) $display("[TB] FAIL div_result_%0d got %h want %h", i, res, ev[i]);
      else pass_cnt++;
      check_cnt++;
      if (pa !== 1'b0) $display("[TB] FAIL div_pulse_%0d got %b want 0", i, pa); else pass_cnt++;
    end
  endtask

  task automatic test_stall_and_latch();
    int n; logic [31:0] res; logic pa;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5, 0, n, res, pa);
    check_cnt++;
    if (n !== 36) $display("[TB] FAIL stall_latency got %0d want 36", n); else pass_cnt++;
    check_cnt++;
    if (res !== 32'hFFFF_FFFD) $display("[TB] FAIL stall_result got %h want fffffffd", res); else pass_cnt++;
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1, n, res, pa);
    check_cnt++;
    if (res !== 32'd14) $display("[TB] FAIL latch_divu got %h want e", res); else pass_cnt++;
    run_op(OP_REMU, 32'd100, 32'd7, 0, 1, n, res, pa);
    check_cnt++;
    if (res !== 32'd2) $display("[TB] FAIL latch_remu got %h want 2", res); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int n; logic [31:0] res; logic pa;
    int seen = 0;
    alu = OP_MUL; rrd1 = 32'd9; rrd2 = 32'd9; rdy = 1'b1;
    @(posedge clk); #1;
    xreset = 1'b0;
    #1;
    check_cnt++;
    if (rwdatx !== 32'd0) $display("[TB] FAIL midreset_rwdatx got %h want 0", rwdatx); else pass_cnt++;
    alu = 5'd0;
    @(posedge clk); #1;
    xreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cmpl) seen++;
      @(posedge clk); #1;
    end
    check_cnt++;
    if (seen !== 0) $display("[TB] FAIL midreset_cmpl got %0d pulses want 0", seen); else pass_cnt++;
    run_op(OP_MUL, 32'd3, 32'd5, 0, 0, n, res, pa);
    check_cnt++;
    if (n !== 2 || res !== 32'd15)
      $display("[TB] FAIL post_reset_mul got n=%0d res=%h want 2/f", n, res);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n = 0, first = 0, second = 0;
    alu = OP_MUL; rrd1 = 32'd6; rrd2 = 32'd7; rdy = 1'b1;
    while (second == 0 && n < 20) begin
      @(posedge clk); #1; n++;
      if (cmpl) begin
        if (first == 0) first = n; else second = n;
      end
    end
    alu = 5'd0;
    check_cnt++;
    if (first !== 2 || second !== 5)
      $display("[TB] FAIL back_to_back_cycles got %0d,%0d want 2,5", first, second);
    else pass_cnt++;
    check_cnt++;
    if (rwdatx !== 32'd42) $display("[TB] FAIL back_to_back_result got %h want 2a", rwdatx); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_stall_and_latch();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/rv_alu.md
Name: rv_alu

Overview:
- Execute-stage ALU of the RV32EMC core; sits between decode/operand registers and the writeback pipeline.
- Single-cycle integer ops (RV32I arithmetic/logic/shift/compare, CSR read pass-through) produce a combinational result.
- M-extension ops (mul/div/rem) run multi-cycle. They are reported through mulop, rwdatx and a one-cycle cmpl pulse, which the core uses to stall and release.

Parameters:
- None. Data width is fixed at 32.

Ports:
- clk     in   1   clock
- xreset  in   1   reset, asynchronous, active-low
- rdy     in   1   pipeline advance enable; all sequential state updates only when rdy=1
- alu     in   5   operation code (alu_t), held stable by core during multi-cycle ops
- rrd1    in   32  operand 1
- rrd2    in   32  operand 2
- csr_rd  in   32  CSR read data
- rwdat   out  32  single-cycle result, combinational
- rwdatx  out  32  multi-cycle result, registered
- cmpl    out  1   multi-cycle op complete, one rdy-cycle pulse
- mulop   out  1   current alu is an M-extension op, combinational

Behaviour:
- alu_t encoding:
  - 0 A_NA, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND, 11 CSR.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code is a no-op.
- mulop = alu[4] (codes 16-23).
- rwdat, single-cycle ops:
  - ADD rrd1+rrd2 mod 2^32; SUB rrd1-rrd2.
  - Shifts use rrd2[4:0] only; SRA is arithmetic.
  - SLT signed / SLTU unsigned compare, result 1 or 0.
  - CSR passes csr_rd.
  - A_NA, M-ops and unused codes give 0.
- FSM states IDLE, BUSY, DONE; transitions only on rdy=1.
- IDLE with mulop=1: latch rrd1, rrd2 and op, enter BUSY.
  - Counter loads 1 for MUL*, 32 for DIV*/REM*.
- BUSY: decrement each rdy cycle.
  - MUL* computes a 64-bit product from sign-adjusted operands: MULH s×s, MULHSU s×u, MULHU u×u.
  - DIV*/REM* performs restoring division, one quotient bit per cycle, on magnitudes; signs are fixed up at the end.
  - At counter 0: rwdatx <= final result, cmpl <= 1, go to DONE.
- DONE: cmpl <= 0, go to IDLE. An M-op still presented in IDLE starts a new operation.
- Latency: cycle 0 is the IDLE cycle where mulop is sampled.
  - cmpl is high during cycle 2 for MUL*, during cycle 33 for DIV*/REM*.
  - rwdatx is valid from the cmpl cycle and held until the next completion.
- Result selection:
  - MUL gives product[31:0]; MULH/MULHSU/MULHU give product[63:32].
  - DIV/DIVU give the quotient, REM/REMU the remainder.
  - Remainder takes the sign of the dividend.
- Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = dividend.
- Signed overflow (0x80000000 / -1): DIV = 0x80000000, REM = 0.
- rdy=0 freezes FSM, counter, rwdatx and cmpl; cmpl stays asserted while frozen in the DONE transition.
- Operand changes during BUSY are ignored (latched copies used).
- Reset, async (xreset=0): state IDLE, counter 0, rwdatx 0, cmpl 0, internal latches 0.
  - Reset mid-operation aborts it with no cmpl.
- rwdat and mulop are purely combinational and unaffected by reset except through their inputs.

Test Plan:
- ADD 0x7FFFFFFF+1 -> rwdat 0x80000000. SUB 0-1 -> 0xFFFFFFFF. SRA 0x80000000 by rrd2=0x21 -> 0xC0000000. SLT 0xFFFFFFFF<1 -> 1; SLTU -> 0. CSR with csr_rd=0x1234 -> 0x1234.
- MUL 0xFFFFFFFF×0xFFFFFFFF -> cmpl in cycle 2; rwdatx: MUL 1, MULH 0, MULHU 0xFFFFFFFE, MULHSU 0xFFFFFFFF. mulop=1 throughout, rwdat=0.
- DIV -7/2 -> quotient 0xFFFFFFFD, REM -7%2 -> 0xFFFFFFFF; cmpl in cycle 33, single pulse.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Toggle rdy=0 for 3 cycles mid-DIV -> cmpl delayed by exactly 3 cycles, result unchanged. Change rrd1 during BUSY -> no effect.
- Assert xreset=0 mid-MUL -> cmpl never pulses, rwdatx=0. After release, next MUL completes normally.
